ats21_cmd_master: RTL and testbench

- Client-side initiator for one ATS21 control port. It is the requester that drives the ATS21 req/ctrl bus and consumes its stat/data outputs.
- Accepts 32-bit ATS21 instructions from a host through a valid/ready queue and serialises each one into two 16-bit beats: top half, then bottom half.
- Samples the per-client Ack/Nack status, retries on Nack and returns one result per command.
- Captures rising edges on the 24 alarm outputs into a sticky, host-clearable pending register.

---
 rtl/ats21_cmd_master.sv | 208 ++++++++++++++++++++
 tb/tb_ats21_cmd_master.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ats21_cmd_master.sv
// ATS21 command initiator: queues 32-bit instructions, issues them as two 16-bit beats, retries on Nack.
// Optional alarm edge capture is built when ATS21_ALARM_CAPTURE_EN is defined.
//
// state | meaning
// IDLE  | wait for a queued command, pop it (nop answers directly)
// TOP   | drive upper instruction half next cycle
// BOT   | drive lower instruction half next cycle
// WAIT  | count RESP_LAT cycles, then sample Ack/Nack
// GAP   | one idle bus cycle; emits the result if one is pending
module ats21_cmd_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLIENT_SEL = 0,
    parameter int RESP_LAT   = 1,
    parameter int MAX_RETRY  = 2,
    parameter int NUM_ALARMS = 24
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [31:0]           cmd_data,
    output logic                  rsp_valid,
    output logic                  rsp_ok,
    output logic [2:0]            rsp_opcode,
    output logic [2:0]            rsp_retries,
    output logic                  ats_req,
    output logic [15:0]           ats_ctrl,
    input  logic [1:0]            ats_stat,
    input  logic [NUM_ALARMS-1:0] ats_data,
    output logic [NUM_ALARMS-1:0] alarm_pending,
    input  logic [NUM_ALARMS-1:0] alarm_clr,
    output logic                  alarm_irq
);

    localparam int              PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]  DEPTH_C     = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [2:0]      MAX_RETRY_C = 3'(MAX_RETRY);
    localparam logic [1:0]      WAIT_LOAD   = 2'(RESP_LAT - 1);
    localparam logic            SEL_C       = CLIENT_SEL[0];

    typedef enum logic [2:0] {S_IDLE, S_TOP, S_BOT, S_WAIT, S_GAP} state_t;

    logic [31:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count, count_nx;
    logic             push, pop;
    logic [31:0]      fifo_head;

    state_t     state, state_nx;
    logic [31:0] cur_cmd;
    logic [2:0] retries, retries_nx;
    logic [1:0] wait_cnt, wait_nx;
    logic       pend, pend_nx, pend_ok, pend_ok_nx;
    logic       ack;
    logic       unused_stat;

    assign push        = cmd_valid && cmd_ready;
    assign fifo_head   = fifo_mem[rd_ptr];
    assign ack         = ats_stat[SEL_C];
    assign unused_stat = ^ats_stat;

    always_comb begin
        count_nx = count;
        if (push && !pop)
            count_nx = count + 1'b1;
        else if (!push && pop)
            count_nx = count - 1'b1;
    end

    // cmd_ready is registered from the next occupancy, so it never sees a same-cycle pop
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cmd_ready <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count     <= count_nx;
            cmd_ready <= count_nx < DEPTH_C;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= cmd_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cur_cmd  <= '0;
            retries  <= '0;
            wait_cnt <= '0;
            pend     <= 1'b0;
            pend_ok  <= 1'b0;
        end else begin
            state    <= state_nx;
            if (pop)
                cur_cmd <= fifo_head;
            retries  <= retries_nx;
            wait_cnt <= wait_nx;
            pend     <= pend_nx;
            pend_ok  <= pend_ok_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        pop        = 1'b0;
        retries_nx = retries;
        wait_nx    = wait_cnt;
        pend_nx    = 1'b0;
        pend_ok_nx = 1'b0;
        case (state)
            S_IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    retries_nx = '0;
                    if (fifo_head[31:29] == 3'b000) begin
                        state_nx   = S_GAP;
                        pend_nx    = 1'b1;
                        pend_ok_nx = 1'b1;
                    end else begin
                        state_nx = S_TOP;
                    end
                end
            end
            S_TOP: state_nx = S_BOT;
            S_BOT: begin
                state_nx = S_WAIT;
                wait_nx  = WAIT_LOAD;
            end
            S_WAIT: begin
                if (wait_cnt == '0) begin
                    state_nx = S_GAP;
                    if (ack) begin
                        pend_nx    = 1'b1;
                        pend_ok_nx = 1'b1;
                    end else if (retries < MAX_RETRY_C) begin
                        retries_nx = retries + 1'b1;
                    end else begin
                        pend_nx = 1'b1;
                    end
                end else begin
                    wait_nx = wait_cnt - 1'b1;
                end
            end
            S_GAP: state_nx = pend ? S_IDLE : S_TOP;
            default: state_nx = S_IDLE;
        endcase
    end

    // Bus and result registers follow the state one cycle later
    always_ff @(posedge clk) begin
        if (reset) begin
            ats_req     <= 1'b0;
            ats_ctrl    <= '0;
            rsp_valid   <= 1'b0;
            rsp_ok      <= 1'b0;
            rsp_opcode  <= '0;
            rsp_retries <= '0;
        end else begin
            ats_req <= (state == S_TOP) || (state == S_BOT);
            case (state)
                S_TOP:   ats_ctrl <= cur_cmd[31:16];
                S_BOT:   ats_ctrl <= cur_cmd[15:0];
                default: ats_ctrl <= '0;
            endcase
            rsp_valid <= (state == S_GAP) && pend;
            if ((state == S_GAP) && pend) begin
                rsp_ok      <= pend_ok;
                rsp_opcode  <= cur_cmd[31:29];
                rsp_retries <= retries;
            end
        end
    end

`ifdef ATS21_ALARM_CAPTURE_EN
    logic [NUM_ALARMS-1:0] ats_data_q;
    logic [NUM_ALARMS-1:0] pending_nx;

    // A rise in the same cycle as a clear keeps the bit set
    assign pending_nx = (alarm_pending & ~alarm_clr) | (ats_data & ~ats_data_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            ats_data_q    <= '0;
            alarm_pending <= '0;
            alarm_irq     <= 1'b0;
        end else begin
            ats_data_q    <= ats_data;
            alarm_pending <= pending_nx;
            alarm_irq     <= |pending_nx;
        end
    end
`else
    logic unused_alarm;

    assign alarm_pending = '0;
    assign alarm_irq     = 1'b0;
    assign unused_alarm  = ^{ats_data, alarm_clr};
`endif

endmodule

// File: tb/tb_ats21_cmd_master.sv
// Self-checking bench for ats21_cmd_master: scoreboard of results, ATS21 responder model, alarm model.
module tb_ats21_cmd_master;

    localparam int FIFO_DEPTH = 4;
    localparam int CLIENT_SEL = 0;
    localparam int RESP_LAT   = 1;
    localparam int MAX_RETRY  = 2;
    localparam int NUM_ALARMS = 24;
`ifdef ATS21_ALARM_CAPTURE_EN
    localparam bit ALARM_EN = 1'b1;
`else
    localparam bit ALARM_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [31:0]           cmd_data;
    logic                  rsp_valid;
    logic                  rsp_ok;
    logic [2:0]            rsp_opcode;
    logic [2:0]            rsp_retries;
    logic                  ats_req;
    logic [15:0]           ats_ctrl;
    logic [1:0]            ats_stat;
    logic [NUM_ALARMS-1:0] ats_data;
    logic [NUM_ALARMS-1:0] alarm_pending;
    logic [NUM_ALARMS-1:0] alarm_clr;
    logic                  alarm_irq;

    ats21_cmd_master #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .CLIENT_SEL(CLIENT_SEL),
        .RESP_LAT  (RESP_LAT),
        .MAX_RETRY (MAX_RETRY),
        .NUM_ALARMS(NUM_ALARMS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ok       (rsp_ok),
        .rsp_opcode   (rsp_opcode),
        .rsp_retries  (rsp_retries),
        .ats_req      (ats_req),
        .ats_ctrl     (ats_ctrl),
        .ats_stat     (ats_stat),
        .ats_data     (ats_data),
        .alarm_pending(alarm_pending),
        .alarm_clr    (alarm_clr),
        .alarm_irq    (alarm_irq)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct packed {
        logic       ok;
        logic [2:0] op;
        logic [2:0] ret;
    } rsp_t;
    typedef struct packed {
        logic [31:0] cmd;
        logic [3:0]  nacks;
    } plan_t;

    rsp_t  exp_q[$];
    plan_t plan_q[$];
    int    t_push, t_top, t_rsp;
    int    n_xact = 0;
    bit    bot_seen = 0;

    // ATS21 responder: checks beats, answers Nack 'nacks' times then Ack
    plan_t cur;
    bit    have_cur = 0;
    int    att = 0;
    int    run = 0;
    bit    ack;
    always @(negedge clk) begin
        if (reset) begin
            run      = 0;
            have_cur = 0;
        end else if (ats_req) begin
            run++;
            if (run == 1) begin
                if (!have_cur) begin
                    chk("req_has_plan", plan_q.size() != 0, 1);
                    if (plan_q.size() != 0) begin
                        cur      = plan_q.pop_front();
                        have_cur = 1;
                        att      = 0;
                    end
                end
                t_top = cyc;
                n_xact++;
                chk("top_beat", ats_ctrl, cur.cmd[31:16]);
            end else if (run == 2) begin
                chk("bot_beat", ats_ctrl, cur.cmd[15:0]);
                ack = (att == int'(cur.nacks));
                att++;
                if (ack || att > MAX_RETRY)
                    have_cur = 0;
                ats_stat[CLIENT_SEL]     = ack;
                ats_stat[1 - CLIENT_SEL] = 1'($urandom_range(0, 1));
                bot_seen = 1;
            end
        end else begin
            if (run != 0)
                chk("req_len", run, 2);
            run = 0;
            chk("ctrl_idle", ats_ctrl, 0);
        end
    end

    // Result monitor
    rsp_t e_mon;
    bit   prev_rsp = 0;
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            t_rsp = cyc;
            chk("rsp_pulse", prev_rsp, 0);
            chk("rsp_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e_mon = exp_q.pop_front();
                chk("rsp_ok", rsp_ok, e_mon.ok);
                chk("rsp_opcode", rsp_opcode, e_mon.op);
                chk("rsp_retries", rsp_retries, e_mon.ret);
            end
        end
        prev_rsp = rsp_valid;
    end

    // Alarm reference: sticky rising-edge capture, clear loses to a same-cycle rise
    logic [NUM_ALARMS-1:0] m_pend = '0;
    logic [NUM_ALARMS-1:0] m_prev = '0;
    always @(posedge clk) begin
        if (reset) begin
            m_pend = '0;
            m_prev = '0;
        end else begin
            if (ALARM_EN)
                m_pend = (m_pend & ~alarm_clr) | (ats_data & ~m_prev);
            m_prev = ats_data;
        end
    end
    always @(negedge clk) begin
        chk("alarm_pending", 32'(alarm_pending), 32'(m_pend));
        chk("alarm_irq", alarm_irq, |m_pend);
    end

    bit alarm_rand = 0;
    always @(posedge clk) begin
        if (alarm_rand) begin
            #1;
            ats_data  = ats_data ^ (24'($urandom) & 24'($urandom) & 24'($urandom));
            alarm_clr = 24'($urandom) & 24'($urandom);
        end
    end

    task automatic push_cmd(input logic [31:0] c, input int nacks);
        rsp_t  e;
        plan_t p;
        int    n = 0;
        while (!cmd_ready && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("push_ready", cmd_ready, 1);
        if (!cmd_ready)
            return;
        cmd_valid = 1'b1;
        cmd_data  = c;
        @(posedge clk);
        #1;
        t_push    = cyc;
        cmd_valid = 1'b0;
        e.op = c[31:29];
        if (e.op == 3'b000) begin
            e.ok  = 1'b1;
            e.ret = 3'd0;
        end else begin
            p.cmd   = c;
            p.nacks = 4'(nacks);
            plan_q.push_back(p);
            e.ok  = (nacks <= MAX_RETRY);
            e.ret = (nacks <= MAX_RETRY) ? 3'(nacks) : 3'(MAX_RETRY);
        end
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    int x0;
    int n;
    logic [2:0] op;
    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        ats_stat  = '0;
        ats_data  = '0;
        alarm_clr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_ats_req", ats_req, 0);
        chk("rst_ats_ctrl", ats_ctrl, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_ok", rsp_ok, 0);
        chk("rst_rsp_opcode", rsp_opcode, 0);
        chk("rst_rsp_retries", rsp_retries, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("ready_after_reset", cmd_ready, 1);

        // Single Ack command and its latencies
        push_cmd(32'h2000_0005, 0);
        drain();
        chk("top_latency", t_top - t_push, 2);
        chk("rsp_latency", t_rsp - t_top, 2 + RESP_LAT);

        // Retries exhausted
        x0 = n_xact;
        push_cmd(32'hA100_0010, 7);
        drain();
        chk("retry_attempts", n_xact - x0, MAX_RETRY + 1);

        // nop: no bus traffic
        x0 = n_xact;
        push_cmd(32'h0000_0000, 0);
        drain();
        chk("nop_latency", t_rsp - t_push, 2);
        chk("nop_no_req", n_xact - x0, 0);

        // Fill: one in flight plus FIFO_DEPTH queued, then the next attempt is refused
        for (int i = 0; i < FIFO_DEPTH + 1; i++)
            push_cmd({3'($urandom_range(1, 7)), 29'($urandom)}, 7);
        chk("ready_full", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_data  = 32'h6000_BEEF;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("ready_still_full", cmd_ready, 0);
        drain();

        // Alarm capture, clear/set collision, clear
        ats_data[3] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        ats_data[3] = 1'b0;
        @(posedge clk);
        #1;
        chk("alarm_set", 32'(alarm_pending), ALARM_EN ? 32'h8 : 32'h0);
        chk("alarm_irq_set", alarm_irq, ALARM_EN);
        ats_data[3]  = 1'b1;
        alarm_clr[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("alarm_clr_vs_rise", 32'(alarm_pending), ALARM_EN ? 32'h8 : 32'h0);
        ats_data[3] = 1'b0;
        @(posedge clk);
        #1;
        alarm_clr = '0;
        chk("alarm_cleared", 32'(alarm_pending), 0);
        chk("alarm_irq_cleared", alarm_irq, 0);

        // Randomised commands with random Nack counts and alarm traffic
        alarm_rand = 1;
        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3);
            repeat (n) @(posedge clk);
            #1;
            op = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            push_cmd({op, 29'($urandom)}, $urandom_range(0, MAX_RETRY + 1));
        end
        drain();
        alarm_rand = 0;
        ats_data   = '0;
        alarm_clr  = '0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while waiting for status
        bot_seen = 0;
        push_cmd(32'h4000_1234, 7);
        n = 0;
        while (!bot_seen && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("reached_wait", bot_seen, 1);
        reset = 1'b1;
        exp_q.delete();
        plan_q.delete();
        repeat (3) begin
            @(negedge clk);
            chk("rstw_ats_req", ats_req, 0);
            chk("rstw_cmd_ready", cmd_ready, 0);
            chk("rstw_rsp_valid", rsp_valid, 0);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("rstw_ready_after", cmd_ready, 1);
        repeat (10) @(posedge clk);
        #1;
        push_cmd(32'h0000_0000, 0);
        push_cmd(32'hE000_00AA, 1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
